rrf_multi_allocate: RTL and testbench

- Parametrised successor to the single-entry RRF allocator in the DP stage.
- Grants up to DP_WIDTH rename-register-file (RRF) entries per cycle and returns a contiguous tag for each granted slot.
- Tracks the free count with up to COM_WIDTH frees per cycle from COM. Keeps an internal commit pointer so a branch-mispredict flush can reclaim all speculative entries in one cycle.
- Also maintains the wrap indicator and a phase bit used for age comparison in the RS/ROB.

---
 rtl/rrf_multi_allocate.sv | 84 ++++++++
 tb/tb_rrf_multi_allocate.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rrf_multi_allocate.sv
// rrf_multi_allocate: multi-slot RRF allocator with commit pointer, flush reclaim and wrap/phase tracking.
// Define RRF_PARTIAL_GRANT_EN to grant as many entries as are available instead of all-or-nothing.
module rrf_multi_allocate #(
  parameter int RRF_NUM   = 64,
  parameter int RRF_SEL   = 6,
  parameter int DP_WIDTH  = 2,
  parameter int COM_WIDTH = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [2:0]                   req_num_i,
  input  logic                         stall_dp_i,
  input  logic [2:0]                   com_num_i,
  input  logic                         flush_i,
  output logic                         rrf_allocatable_o,
  output logic [2:0]                   grant_num_o,
  output logic [DP_WIDTH*RRF_SEL-1:0]  rrftag_o,
  output logic [RRF_SEL:0]             freenum_o,
  output logic [RRF_SEL-1:0]           rrfptr_o,
  output logic [RRF_SEL-1:0]           comptr_o,
  output logic                         rrf_phase_o,
  output logic                         nextrrfcyc_o
);
  localparam logic [RRF_SEL:0]   num1 = (RRF_SEL+1)'(RRF_NUM);
  localparam logic [RRF_SEL+1:0] num2 = (RRF_SEL+2)'(RRF_NUM);
  // Sums stay below 2*RRF_NUM, so one conditional subtraction replaces a modulo.
  function automatic logic [RRF_SEL-1:0] wrap(input logic [RRF_SEL:0] s);
    return s >= num1 ? RRF_SEL'(s - num1) : s[RRF_SEL-1:0];
  endfunction
  logic [2:0]           req, com, grant;
  logic [RRF_SEL+1:0]   avail, free_nxt, occ;
  logic [RRF_SEL:0]     rsum, csum;
  logic [RRF_SEL-1:0]   comptr_nxt;
  logic                 fire, wrapped, cwrap, comphase;
  always_comb begin
    req               = req_num_i > 3'(DP_WIDTH) ? 3'(DP_WIDTH) : req_num_i;
    com               = com_num_i > 3'(COM_WIDTH) ? 3'(COM_WIDTH) : com_num_i;
    avail             = {1'b0, freenum_o} + (RRF_SEL+2)'(com);
    rrf_allocatable_o = avail >= (RRF_SEL+2)'(req);
    fire              = ~stall_dp_i & ~flush_i & rrf_allocatable_o & (req != 3'd0);
`ifdef RRF_PARTIAL_GRANT_EN
    grant             = (~stall_dp_i & ~flush_i) ? (rrf_allocatable_o ? req : avail[2:0]) : 3'd0;
`else
    grant             = fire ? req : 3'd0;
`endif
    rsum              = {1'b0, rrfptr_o} + (RRF_SEL+1)'(grant);
    csum              = {1'b0, comptr_o} + (RRF_SEL+1)'(com);
    wrapped           = rsum >= num1;
    cwrap             = csum >= num1;
    comptr_nxt        = wrap(csum);
    free_nxt          = avail - (RRF_SEL+2)'(grant);
    occ               = num2 - {1'b0, freenum_o};
  end
  assign grant_num_o = grant;
  for (genvar i = 0; i < DP_WIDTH; i++) begin : g_tag
    assign rrftag_o[i*RRF_SEL +: RRF_SEL] = wrap({1'b0, rrfptr_o} + (RRF_SEL+1)'(i));
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      freenum_o    <= num1;
      rrfptr_o     <= '0;
      comptr_o     <= '0;
      comphase     <= 1'b0;
      rrf_phase_o  <= 1'b0;
      nextrrfcyc_o <= 1'b0;
    end else begin
      comptr_o <= comptr_nxt;
      comphase <= comphase ^ cwrap;
      if (flush_i) begin
        rrfptr_o     <= comptr_nxt;
        freenum_o    <= num1;
        rrf_phase_o  <= comphase ^ cwrap;
        nextrrfcyc_o <= 1'b0;
      end else begin
        rrfptr_o     <= wrap(rsum);
        freenum_o    <= free_nxt > num2 ? num1 : free_nxt[RRF_SEL:0];
        rrf_phase_o  <= rrf_phase_o ^ wrapped;
        nextrrfcyc_o <= wrapped;
      end
    end
  end
  // Retiring more entries than are live indicates a COM-stage bug.
  a_legal_commit: assert property (@(posedge clk_i) disable iff (reset_i) (RRF_SEL+2)'(com) <= occ);
endmodule

// File: tb/tb_rrf_multi_allocate.sv
// tb_rrf_multi_allocate: vector table, corner sequences and random traffic against a counter-based model.
module tb_rrf_multi_allocate;
  localparam int N = 64, SEL = 6, DPW = 2, COMW = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_i = 1'b1, stall_dp_i = 1'b0, flush_i = 1'b0;
  logic [2:0] req_num_i = '0, com_num_i = '0;
  logic rrf_allocatable_o, rrf_phase_o, nextrrfcyc_o;
  logic [2:0] grant_num_o;
  logic [DPW*SEL-1:0] rrftag_o;
  logic [SEL:0] freenum_o;
  logic [SEL-1:0] rrfptr_o, comptr_o;
  rrf_multi_allocate #(.RRF_NUM(N), .RRF_SEL(SEL), .DP_WIDTH(DPW), .COM_WIDTH(COMW)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_num_i(req_num_i), .stall_dp_i(stall_dp_i),
    .com_num_i(com_num_i), .flush_i(flush_i), .rrf_allocatable_o(rrf_allocatable_o),
    .grant_num_o(grant_num_o), .rrftag_o(rrftag_o), .freenum_o(freenum_o), .rrfptr_o(rrfptr_o),
    .comptr_o(comptr_o), .rrf_phase_o(rrf_phase_o), .nextrrfcyc_o(nextrrfcyc_o)
  );
  int n_tests = 0, n_fail = 0;
  // Model: lifetime totals of allocated and committed entries; everything else derives from them.
  longint at = 0, ct = 0;
  bit nrc = 1'b0;
  logic lg_alloc;
  int lg_grant, lg_t0, lg_t1;
  typedef struct {
    int rq, cm; bit st, fl;
    bit alloc; int grant, t0, t1, free, rp, cp;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string nm, input longint a, input longint e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask
  task automatic step(input int rq, input int cm, input bit st, input bit fl, input bit rs);
    int r, c, g;
    longint fr;
    bit al;
    @(negedge clk);
    req_num_i = 3'(rq); com_num_i = 3'(cm); stall_dp_i = st; flush_i = fl; reset_i = rs;
    #1;
    r = rq > DPW ? DPW : rq;
    c = cm > COMW ? COMW : cm;
    fr = N - (at - ct);
    al = (fr + c) >= r;
`ifdef RRF_PARTIAL_GRANT_EN
    g = (!st && !fl) ? ((r < fr + c) ? r : int'(fr + c)) : 0;
`else
    g = (!st && !fl && al && r != 0) ? r : 0;
`endif
    lg_alloc = rrf_allocatable_o;
    lg_grant = int'(grant_num_o);
    lg_t0 = int'(rrftag_o[SEL-1:0]);
    lg_t1 = int'(rrftag_o[2*SEL-1:SEL]);
    if (!rs) begin
      chk("allocatable", longint'(rrf_allocatable_o), longint'(al));
      chk("grant", longint'(grant_num_o), g);
      for (int i = 0; i < g; i++) chk("tag", longint'(rrftag_o[i*SEL +: SEL]), (at + i) % N);
    end
    @(posedge clk);
    #1;
    if (rs) begin
      at = 0; ct = 0; nrc = 1'b0;
    end else begin
      ct += c;
      if (fl) begin
        at = ct; nrc = 1'b0;
      end else begin
        nrc = (g != 0) && ((at / N) != ((at + g) / N));
        at += g;
      end
    end
    chk("freenum", longint'(freenum_o), N - (at - ct));
    chk("rrfptr", longint'(rrfptr_o), at % N);
    chk("comptr", longint'(comptr_o), ct % N);
    chk("phase", longint'(rrf_phase_o), (at / N) % 2);
    chk("nextrrfcyc", longint'(nextrrfcyc_o), longint'(nrc));
  endtask
  initial begin
    tbl[0] = '{2, 0, 1'b0, 1'b0, 1'b1, 2, 0, 1, 62, 2, 0};
    tbl[1] = '{2, 0, 1'b0, 1'b0, 1'b1, 2, 2, 3, 60, 4, 0};
    tbl[2] = '{2, 0, 1'b0, 1'b0, 1'b1, 2, 4, 5, 58, 6, 0};
    tbl[3] = '{7, 7, 1'b0, 1'b0, 1'b1, 2, 6, 7, 58, 8, 2};
    tbl[4] = '{2, 2, 1'b1, 1'b0, 1'b1, 0, 8, 9, 60, 8, 4};
    tbl[5] = '{0, 1, 1'b0, 1'b0, 1'b1, 0, 8, 9, 61, 8, 5};
    tbl[6] = '{2, 1, 1'b0, 1'b1, 1'b1, 0, 8, 9, 64, 6, 6};
    tbl[7] = '{1, 0, 1'b0, 1'b0, 1'b1, 1, 6, 7, 63, 7, 6};
    step(0, 0, 0, 0, 1);
    chk("rst_freenum", longint'(freenum_o), 64);
    chk("rst_rrfptr", longint'(rrfptr_o), 0);
    chk("rst_comptr", longint'(comptr_o), 0);
    chk("rst_phase", longint'(rrf_phase_o), 0);
    chk("rst_nextrrfcyc", longint'(nextrrfcyc_o), 0);
    foreach (tbl[k]) begin
      step(tbl[k].rq, tbl[k].cm, tbl[k].st, tbl[k].fl, 0);
      chk("vec_alloc", longint'(lg_alloc), longint'(tbl[k].alloc));
      chk("vec_grant", lg_grant, tbl[k].grant);
      chk("vec_tag0", lg_t0, tbl[k].t0);
      chk("vec_tag1", lg_t1, tbl[k].t1);
      chk("vec_free", longint'(freenum_o), tbl[k].free);
      chk("vec_rrfptr", longint'(rrfptr_o), tbl[k].rp);
      chk("vec_comptr", longint'(comptr_o), tbl[k].cp);
    end
    // Fill to one free entry, then probe the full boundary and the pointer wrap.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 31; i++) step(2, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("fill_free", longint'(freenum_o), 1);
    chk("fill_rrfptr", longint'(rrfptr_o), 63);
    step(2, 0, 0, 0, 0);
    chk("full_alloc", longint'(lg_alloc), 0);
`ifdef RRF_PARTIAL_GRANT_EN
    chk("partial_grant", lg_grant, 1);
    chk("partial_free", longint'(freenum_o), 0);
    chk("partial_rrfptr", longint'(rrfptr_o), 0);
    step(2, 1, 0, 0, 0);
    chk("partial2_grant", lg_grant, 1);
    chk("partial2_free", longint'(freenum_o), 0);
`else
    chk("full_grant", lg_grant, 0);
    chk("full_free", longint'(freenum_o), 1);
    chk("full_rrfptr", longint'(rrfptr_o), 63);
    step(2, 1, 0, 0, 0);
    chk("wrap_grant", lg_grant, 2);
    chk("wrap_tag0", lg_t0, 63);
    chk("wrap_tag1", lg_t1, 0);
    chk("wrap_free", longint'(freenum_o), 0);
    chk("wrap_rrfptr", longint'(rrfptr_o), 1);
    chk("wrap_phase", longint'(rrf_phase_o), 1);
    chk("wrap_nextrrfcyc", longint'(nextrrfcyc_o), 1);
`endif
    step(0, 0, 0, 0, 0);
    chk("wrap_nextrrfcyc_drop", longint'(nextrrfcyc_o), 0);
    // Flush with simultaneous commits from comptr=10, rrfptr=30, freenum=44.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) step(2, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 2, 0, 0, 0);
    chk("pre_flush_free", longint'(freenum_o), 44);
    step(2, 2, 0, 1, 0);
    chk("flush_grant", lg_grant, 0);
    chk("flush_comptr", longint'(comptr_o), 12);
    chk("flush_rrfptr", longint'(rrfptr_o), 12);
    chk("flush_free", longint'(freenum_o), 64);
    // Stall with commits from freenum=40.
    for (int i = 0; i < 12; i++) step(2, 0, 0, 0, 0);
    chk("pre_stall_free", longint'(freenum_o), 40);
    step(2, 2, 1, 0, 0);
    chk("stall_grant", lg_grant, 0);
    chk("stall_free", longint'(freenum_o), 42);
    chk("stall_rrfptr", longint'(rrfptr_o), 36);
    chk("stall_comptr", longint'(comptr_o), 14);
    // Random traffic with only legal commit counts.
    for (int n = 0; n < 3000; n++) begin
      int rq, cm;
      longint occ;
      occ = at - ct;
      rq = int'($urandom_range(0, 7));
      cm = (occ >= COMW) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 32'(occ)));
      step(rq, cm, $urandom_range(0, 5) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 400) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
